// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp_guard output stage: lamp codes, guard FSM
// states, fault codes and the per-sample legality helpers.
// Optional feature macro used by the design: LAMP_PWM_EN (lamp dimming).
package lamp_pkg;

  // Lamp drive codes, one bit per bulb: bit0 red, bit1 amber, bit2 green
  localparam logic [2:0] LAMP_OFF   = 3'b000;
  localparam logic [2:0] LAMP_RED   = 3'b001;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_GREEN = 3'b100;

  // Guard FSM states
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    PENDING = 2'd1,
    SAFE    = 2'd2
  } guard_state_t;

  // Fault codes reported while in SAFE
  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_A    = 2'b01;
  localparam logic [1:0] FAULT_B    = 2'b10;
  localparam logic [1:0] FAULT_DUAL = 2'b11;

  // A head code is legal only when exactly one bulb is requested
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == LAMP_RED) || (v == LAMP_AMBER) || (v == LAMP_GREEN);
  endfunction

  // Classify one sample; dual green outranks a malformed A, which outranks B
  function automatic logic [1:0] classify(input logic [2:0] a, input logic [2:0] b);
    logic [1:0] code;
    code = FAULT_NONE;
    if ((a == LAMP_GREEN) && (b == LAMP_GREEN)) begin
      code = FAULT_DUAL;
    end else if (!is_onehot3(a)) begin
      code = FAULT_A;
    end else if (!is_onehot3(b)) begin
      code = FAULT_B;
    end
    return code;
  endfunction

endpackage

// File: rtl/lamp_pwm.sv
// Lamp dimmer: free-running counter compared against the duty input, used to
// gate every lit bit of both registered lamp heads. Only instantiated when the
// design is built with LAMP_PWM_EN.
module lamp_pwm #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [2:0]          a_raw,
  input  logic [2:0]          b_raw,
  output logic [2:0]          a_gated,
  output logic [2:0]          b_gated
);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;
  logic                gate;

  // Next count simply wraps through the full range
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  end

  // Free-running dimming counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // All-ones duty is a steady on; otherwise lit for duty out of 2**PWM_BITS cycles
  always_comb begin
    gate    = (&duty) | (pwm_cnt_q < duty);
    a_gated = a_raw & {3{gate}};
    b_gated = b_raw & {3{gate}};
  end

endmodule

// File: rtl/lamp_guard.sv
// Output stage behind the traffic-light sequencer. Registers both head codes,
// filters short bursts of illegal codes, and falls back to flashing amber on a
// persistent fault until a clear request arrives with legal inputs.
// Optional feature: define LAMP_PWM_EN to add the duty port and lamp dimming.
module lamp_guard
  import lamp_pkg::*;
#(
  parameter int FAULT_CYC  = 4,
  parameter int BLINK_HALF = 25_000_000,
  parameter int PWM_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          a_in,
  input  logic [2:0]          b_in,
  input  logic                fault_clr,
`ifdef LAMP_PWM_EN
  input  logic [PWM_BITS-1:0] duty,
`endif
  output logic [2:0]          lamp_a,
  output logic [2:0]          lamp_b,
  output logic                fault,
  output logic [1:0]          fault_code
);

  // Counter widths; the illegal counter must be able to hold FAULT_CYC-1
  localparam int CW = (FAULT_CYC > 1) ? $clog2(FAULT_CYC + 1) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(FAULT_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  // Reject meaningless parameter values at elaboration
  if (FAULT_CYC < 1) begin : g_bad_fault_cyc
    $error("lamp_guard: FAULT_CYC must be at least 1");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink_half
    $error("lamp_guard: BLINK_HALF must be at least 1");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm_bits
    $error("lamp_guard: PWM_BITS must be at least 1");
  end

  guard_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [2:0]    lamp_a_q, lamp_a_d;
  logic [2:0]    lamp_b_q, lamp_b_d;
  logic          fault_q, fault_d;
  logic [1:0]    code_q, code_d;

  logic [1:0]    sample_code;
  logic          legal;

  // Per-cycle legality of the incoming pair
  always_comb begin
    sample_code = classify(a_in, b_in);
    legal       = (sample_code == FAULT_NONE);
  end

  // State and datapath registers; reset forces all-red and NORMAL
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      cnt_q    <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b1;
      lamp_a_q <= LAMP_RED;
      lamp_b_q <= LAMP_RED;
      fault_q  <= 1'b0;
      code_q   <= FAULT_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      lamp_a_q <= lamp_a_d;
      lamp_b_q <= lamp_b_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  // Next-state logic: glitch filter, fault latch, safe-mode flasher and clear
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q;
    phase_d  = phase_q;
    lamp_a_d = lamp_a_q;
    lamp_b_d = lamp_b_q;
    fault_d  = fault_q;
    code_d   = code_q;

    unique case (state_q)
      NORMAL: begin
        if (legal) begin
          lamp_a_d = a_in;
          lamp_b_d = b_in;
        end else if (FAULT_CYC == 1) begin
          // No filtering window: the first bad sample latches the fault
          state_d  = SAFE;
          fault_d  = 1'b1;
          code_d   = sample_code;
          blink_d  = '0;
          phase_d  = 1'b1;
          lamp_a_d = LAMP_AMBER;
          lamp_b_d = LAMP_AMBER;
        end else begin
          // Lamps keep their last good value while we wait it out
          state_d = PENDING;
          cnt_d   = CW'(1);
        end
      end

      PENDING: begin
        if (legal) begin
          state_d  = NORMAL;
          cnt_d    = '0;
          lamp_a_d = a_in;
          lamp_b_d = b_in;
        end else if (cnt_q == CNT_LAST) begin
          // The reported code is that of the sample which tipped it over
          state_d  = SAFE;
          cnt_d    = '0;
          fault_d  = 1'b1;
          code_d   = sample_code;
          blink_d  = '0;
          phase_d  = 1'b1;
          lamp_a_d = LAMP_AMBER;
          lamp_b_d = LAMP_AMBER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SAFE: begin
        if (fault_clr && legal) begin
          state_d  = NORMAL;
          cnt_d    = '0;
          fault_d  = 1'b0;
          code_d   = FAULT_NONE;
          lamp_a_d = a_in;
          lamp_b_d = b_in;
        end else begin
          // Half-period timer; the lamps follow the phase it produces
          if (blink_q == BLINK_LAST) begin
            blink_d  = '0;
            phase_d  = ~phase_q;
            lamp_a_d = phase_q ? LAMP_OFF : LAMP_AMBER;
            lamp_b_d = phase_q ? LAMP_OFF : LAMP_AMBER;
          end else begin
            blink_d  = blink_q + BW'(1);
            lamp_a_d = phase_q ? LAMP_AMBER : LAMP_OFF;
            lamp_b_d = phase_q ? LAMP_AMBER : LAMP_OFF;
          end
        end
      end

      default: begin
        state_d = NORMAL;
      end
    endcase
  end

  // Fault status comes straight from its registers
  always_comb begin
    fault      = fault_q;
    fault_code = code_q;
  end

`ifdef LAMP_PWM_EN
  logic [2:0] lamp_a_pwm;
  logic [2:0] lamp_b_pwm;

  lamp_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .duty    (duty),
    .a_raw   (lamp_a_q),
    .b_raw   (lamp_b_q),
    .a_gated (lamp_a_pwm),
    .b_gated (lamp_b_pwm)
  );

  // Dimmed lamp drive, gated after the output register in every state
  always_comb begin
    lamp_a = lamp_a_pwm;
    lamp_b = lamp_b_pwm;
  end
`else
  // Full-level lamp drive straight from the output register
  always_comb begin
    lamp_a = lamp_a_q;
    lamp_b = lamp_b_q;
  end
`endif

endmodule

// File: tb/tb_lamp_guard.sv
// Self-checking bench for lamp_guard (FAULT_CYC=4, BLINK_HALF=8, PWM_BITS=4).
// Builds with or without LAMP_PWM_EN.
module tb_lamp_guard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] a_in;
  logic [2:0] b_in;
  logic       fault_clr;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic       fault;
  logic [1:0] fault_code;
`ifdef LAMP_PWM_EN
  logic [3:0] duty;
`endif

  always #5 clk = ~clk;

  lamp_guard #(
    .FAULT_CYC  (4),
    .BLINK_HALF (8),
    .PWM_BITS   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_in       (a_in),
    .b_in       (b_in),
    .fault_clr  (fault_clr),
`ifdef LAMP_PWM_EN
    .duty       (duty),
`endif
    .lamp_a     (lamp_a),
    .lamp_b     (lamp_b),
    .fault      (fault),
    .fault_code (fault_code)
  );

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       clr;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       ef;
    logic [1:0] ec;
  } vec_t;

  typedef struct {
    int         tag;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       ef;
    logic [1:0] ec;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add_vec(input logic [2:0] a, input logic [2:0] b, input logic clr,
                         input logic [2:0] ea, input logic [2:0] eb,
                         input logic ef, input logic [1:0] ec);
    vec_t v;
    v.a = a; v.b = b; v.clr = clr; v.ea = ea; v.eb = eb; v.ef = ef; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string nm, input int tag, input logic [2:0] act, input logic [2:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s step %0d: got %b, want %b", nm, tag, act, req);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now
  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: empty queue, nothing to compare");
      return;
    end
    e = sb.pop_front();
    cmp("lamp_a", e.tag, lamp_a, e.ea);
    cmp("lamp_b", e.tag, lamp_b, e.eb);
    cmp("fault", e.tag, {2'b00, fault}, {2'b00, e.ef});
    cmp("fault_code", e.tag, {1'b0, fault_code}, {1'b0, e.ec});
    $display("step %0d: a_in=%b b_in=%b clr=%b rst_n=%b -> lamp_a=%b lamp_b=%b fault=%b code=%b",
             e.tag, a_in, b_in, fault_clr, rst_n, lamp_a, lamp_b, fault, fault_code);
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge
  int step_no = 0;
  task automatic apply(input logic [2:0] a, input logic [2:0] b, input logic clr,
                       input logic [2:0] ea, input logic [2:0] eb,
                       input logic ef, input logic [1:0] ec);
    exp_t e;
    a_in = a; b_in = b; fault_clr = clr;
    e.tag = step_no; e.ea = ea; e.eb = eb; e.ef = ef; e.ec = ec;
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
    check_head();
  endtask

  // Hold reset low for n edges; every edge must show the reset outputs
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      apply(3'b100, 3'b100, 1'b0, 3'b001, 3'b001, 1'b0, 2'b00);
    end
    rst_n = 1'b1;
  endtask

  // Safe-mode flasher: k edges after entry, amber during even half-periods
  task automatic blink_check(input int k, input logic [2:0] a, input logic [2:0] b,
                             input logic clr, input logic [1:0] code);
    logic [2:0] lit;
    lit = (((k / 8) % 2) == 0) ? 3'b010 : 3'b000;
    apply(a, b, clr, lit, lit, 1'b1, code);
  endtask

`ifdef LAMP_PWM_EN
  // Count lit cycles over one PWM period with steady 001/100 inputs
  task automatic pwm_window(input logic [3:0] d, input int want_on);
    int on_a;
    int on_b;
    int stray;
    duty = d;
    on_a = 0; on_b = 0; stray = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (lamp_a[0]) on_a++;
      if (lamp_b[2]) on_b++;
      if ((lamp_a & 3'b110) != 3'b000 || (lamp_b & 3'b011) != 3'b000) stray++;
    end
    $display("pwm duty=%0d: head A lit %0d/16, head B lit %0d/16, stray %0d", d, on_a, on_b, stray);
    n_checks++;
    if (on_a == want_on) n_pass++;
    else $display("FAIL pwm_a duty=%0d: got %0d lit cycles, want %0d", d, on_a, want_on);
    n_checks++;
    if (on_b == want_on) n_pass++;
    else $display("FAIL pwm_b duty=%0d: got %0d lit cycles, want %0d", d, on_b, want_on);
    n_checks++;
    if (stray == 0) n_pass++;
    else $display("FAIL pwm_stray duty=%0d: got %0d cycles with unlit bits on, want 0", d, stray);
  endtask
`endif

  initial begin
    rst_n = 1'b0; a_in = 3'b000; b_in = 3'b000; fault_clr = 1'b0;
`ifdef LAMP_PWM_EN
    duty = 4'hF;
`endif

    // Table: pass-through, glitch filter, fault_clr ignored, dual-green fault
    add_vec(3'b001, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00);
    add_vec(3'b011, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00);
    add_vec(3'b011, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00);
    add_vec(3'b011, 3'b100, 1'b0, 3'b001, 3'b100, 1'b0, 2'b00);
    add_vec(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00);
    add_vec(3'b010, 3'b001, 1'b1, 3'b010, 3'b001, 1'b0, 2'b00);
    add_vec(3'b100, 3'b100, 1'b0, 3'b010, 3'b001, 1'b0, 2'b00);
    add_vec(3'b100, 3'b100, 1'b0, 3'b010, 3'b001, 1'b0, 2'b00);
    add_vec(3'b100, 3'b100, 1'b1, 3'b010, 3'b001, 1'b0, 2'b00);
    add_vec(3'b100, 3'b100, 1'b0, 3'b010, 3'b010, 1'b1, 2'b11);

    // 1. Reset for two edges
    do_reset(2);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].clr, vecs[i].ea, vecs[i].eb, vecs[i].ef, vecs[i].ec);
    end

    // 3/4. Flashing amber; clears with illegal inputs are ignored
    for (int k = 1; k <= 18; k++) begin
      if (k == 3)      blink_check(k, 3'b100, 3'b100, 1'b1, 2'b11);
      else if (k == 5) blink_check(k, 3'b011, 3'b001, 1'b1, 2'b11);
      else             blink_check(k, 3'b100, 3'b100, 1'b0, 2'b11);
    end
    // Legal inputs alone do not leave SAFE
    blink_check(19, 3'b001, 3'b100, 1'b0, 2'b11);

    // Legal clear returns to NORMAL with the inputs loaded on the same edge
    apply(3'b001, 3'b100, 1'b1, 3'b001, 3'b100, 1'b0, 2'b00);
    apply(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00);

    // Second fault: code taken from the fourth sample (B malformed)
    apply(3'b000, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00);
    apply(3'b000, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00);
    apply(3'b000, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00);
    apply(3'b001, 3'b011, 1'b0, 3'b010, 3'b010, 1'b1, 2'b10);
    // Flasher restarted: a full amber half-period again
    for (int k = 1; k <= 9; k++) begin
      blink_check(k, 3'b001, 3'b011, 1'b0, 2'b10);
    end

    // 5. Reset during SAFE, then plain pass-through
    do_reset(1);
    apply(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'b00);
    apply(3'b010, 3'b001, 1'b0, 3'b010, 3'b001, 1'b0, 2'b00);

    // Glitch exactly one short of the limit, then A malformed fault code
    apply(3'b110, 3'b001, 1'b0, 3'b010, 3'b001, 1'b0, 2'b00);
    apply(3'b110, 3'b001, 1'b0, 3'b010, 3'b001, 1'b0, 2'b00);
    apply(3'b110, 3'b001, 1'b0, 3'b010, 3'b001, 1'b0, 2'b00);
    apply(3'b110, 3'b001, 1'b0, 3'b010, 3'b010, 1'b1, 2'b01);
    apply(3'b001, 3'b100, 1'b1, 3'b001, 3'b100, 1'b0, 2'b00);

`ifdef LAMP_PWM_EN
    // 6. Dimming with steady legal inputs in NORMAL
    a_in = 3'b001; b_in = 3'b100; fault_clr = 1'b0;
    pwm_window(4'd4, 4);
    pwm_window(4'd15, 16);
    pwm_window(4'd0, 0);
    duty = 4'hF;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
